// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controllers: light encodings,
// phase-state encoding, phase indices and small decode helpers.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        PS_ALL_RED = 2'b00,
        PS_GREEN   = 2'b01,
        PS_YELLOW  = 2'b10
    } phase_state_t;

    localparam logic [1:0] NS_THRU = 2'd0;
    localparam logic [1:0] EW_THRU = 2'd1;
    localparam logic [1:0] NS_LEFT = 2'd2;
    localparam logic [1:0] EW_LEFT = 2'd3;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Granted phase shows the current colour; every other phase is red.
    function automatic logic [11:0] light_word(input phase_state_t ps, input logic [3:0] g);
        logic [11:0] lw;
        lw = '0;
        for (int i = 0; i < 4; i++) begin
            if (g[i] && ps == PS_GREEN)
                lw[3*i +: 3] = LIGHT_GREEN;
            else if (g[i] && ps == PS_YELLOW)
                lw[3*i +: 3] = LIGHT_YELLOW;
            else
                lw[3*i +: 3] = LIGHT_RED;
        end
        return lw;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational four-way round-robin arbiter: the first set request bit
// after the last-served index wins, wrapping modulo 4.
module rr_arbiter4 (
    input  logic [3:0] req_mask,
    input  logic [1:0] last,
    output logic [3:0] winner,
    output logic       valid
);

    logic [1:0] idx;

    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (winner == '0 && req_mask[idx]) winner[idx] = 1'b1;
        end
    end

    assign valid = |req_mask;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Tick-driven four-phase green-time scheduler with min/max green, yellow,
// all-red clearance and a manual/emergency hold that forces all-red.
//
// state      | meaning
// PS_ALL_RED | clearance interval, or idle (timer 0) waiting for a request
// PS_GREEN   | granted phase green; gap-out / max-out / dwell decided per tick
// PS_YELLOW  | granted phase yellow, then clearance
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TW        = 4,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 10,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [3:0]    req,
    input  logic          hold,
    output logic [3:0]    grant,
    output logic [11:0]   light,
    output logic [1:0]    phase_state,
    output logic [TW-1:0] timer
);

    localparam logic [TW-1:0] T_MAX    = TW'(MAX_GREEN);
    localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW);
    localparam logic [TW-1:0] T_ALLRED = TW'(ALL_RED);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    // Elapsed green e = MAX - t + 1 reaches MIN once t drops to this value.
    localparam logic [TW-1:0] T_GAP_OK = TW'(MAX_GREEN - MIN_GREEN + 1);

    phase_state_t  state, state_n;
    logic [3:0]    grant_n;
    logic [TW-1:0] timer_n;
    logic [1:0]    ptr, ptr_n;

    logic [3:0] arb_mask;
    logic [3:0] arb_winner;
    logic       arb_valid;
    logic       own_req;
    logic       gap_out;
    logic       max_out;

    // In GREEN the arbiter only answers "is anyone else waiting?".
    assign arb_mask = (state == PS_GREEN) ? (req & ~grant) : req;

    rr_arbiter4 u_arb (
        .req_mask (arb_mask),
        .last     (ptr),
        .winner   (arb_winner),
        .valid    (arb_valid)
    );

    assign own_req = |(req & grant);
    assign gap_out = (timer <= T_GAP_OK) && !own_req && arb_valid;
    assign max_out = (timer == T_ONE) && arb_valid;

    always_comb begin
        state_n = state;
        grant_n = grant;
        timer_n = timer;
        ptr_n   = ptr;
        case (state)
            PS_ALL_RED: begin
                if (tick) begin
                    if (timer <= T_ONE) begin
                        if (!hold && arb_valid) begin
                            state_n = PS_GREEN;
                            grant_n = arb_winner;
                            timer_n = T_MAX;
                            ptr_n   = onehot_to_idx(arb_winner);
                        end else begin
                            timer_n = '0;
                        end
                    end else begin
                        timer_n = timer - T_ONE;
                    end
                end
            end
            PS_GREEN: begin
                if (hold) begin
                    state_n = PS_YELLOW;
                    timer_n = T_YELLOW;
                end else if (tick) begin
                    if (gap_out || max_out) begin
                        state_n = PS_YELLOW;
                        timer_n = T_YELLOW;
                    end else if (timer == T_ONE) begin
                        timer_n = T_MAX;
                    end else begin
                        timer_n = timer - T_ONE;
                    end
                end
            end
            PS_YELLOW: begin
                if (tick) begin
                    if (timer <= T_ONE) begin
                        state_n = PS_ALL_RED;
                        timer_n = T_ALLRED;
                        grant_n = '0;
                    end else begin
                        timer_n = timer - T_ONE;
                    end
                end
            end
            default: begin
                state_n = PS_ALL_RED;
                grant_n = '0;
                timer_n = T_ALLRED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PS_ALL_RED;
            grant <= '0;
            timer <= T_ALLRED;
            ptr   <= EW_LEFT;
            light <= {LIGHT_RED, LIGHT_RED, LIGHT_RED, LIGHT_RED};
        end else begin
            state <= state_n;
            grant <= grant_n;
            timer <= timer_n;
            ptr   <= ptr_n;
            light <= light_word(state_n, grant_n);
        end
    end

    assign phase_state = state;

endmodule
